// File: rtl/flag_branch_unit.sv
// ============================================================================
//  Module      : flag_branch_unit
//  Description : Architectural NZCV flag register plus conditional-branch
//                resolution (B, CBZ, B.EQ, B.LT) with a registered redirect
//                strobe and a FLUSH_LEN-cycle wrong-path squash window.
//                Build option: define FLAG_BYPASS_EN to resolve B.EQ/B.LT
//                from same-cycle ALU flags; leave it undefined to insert a
//                one-cycle WAIT (with stall_req) instead.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_branch_unit #(
    parameter int ADDR_W    = 64,
    parameter int FLUSH_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic [3:0]        ex_nzcv,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic              cbz_zero,
    input  logic [ADDR_W-1:0] br_target,
    output logic [3:0]        flags,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_pc,
    output logic              flush_req,
    output logic              stall_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Branch type encodings
    localparam logic [1:0] c_br_b    = 2'b00;
    localparam logic [1:0] c_br_cbz  = 2'b01;
    localparam logic [1:0] c_br_beq  = 2'b10;

    // Last FLUSH counter value before returning to IDLE
    localparam logic [1:0] c_cnt_last = 2'(FLUSH_LEN - 1);

`ifdef FLAG_BYPASS_EN
    localparam bit c_bypass_en = 1'b1;
`else
    localparam bit c_bypass_en = 1'b0;
`endif

    state_t            state_q,     state_d;
    logic [1:0]        cnt_q,       cnt_d;
    logic [3:0]        flags_q,     flags_d;
    logic [ADDR_W-1:0] br_pc_q,     br_pc_d;
    logic              br_taken_q,  br_taken_d;
    logic              flush_req_q, flush_req_d;
    logic              stall_req_q, stall_req_d;
    logic [1:0]        wait_type_q, wait_type_d;
    logic [ADDR_W-1:0] wait_tgt_q,  wait_tgt_d;

    logic              flag_wr;
    logic [3:0]        eff_flags;

    // Taken condition; nzcv is {N,Z,C,V}
    function automatic logic taken_f(input logic [1:0] typ,
                                     input logic       zero,
                                     input logic [3:0] nzcv);
        logic t;
        case (typ)
            c_br_b:   t = 1'b1;
            c_br_cbz: t = zero;
            c_br_beq: t = nzcv[2];
            default:  t = nzcv[3] ^ nzcv[0];
        endcase
        return t;
    endfunction

    // Flag write enable and the flag view used for resolution in IDLE
    always_comb begin
        flag_wr   = ex_valid && ex_set_flags && (state_q != FLUSH);
        eff_flags = (c_bypass_en && flag_wr) ? ex_nzcv : flags_q;
    end

    // Next-state, flag and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        br_pc_d     = br_pc_q;
        wait_type_d = wait_type_q;
        wait_tgt_d  = wait_tgt_q;
        br_taken_d  = 1'b0;
        flush_req_d = 1'b0;
        stall_req_d = 1'b0;

        // Wrong-path instructions in FLUSH never touch the flags
        if (flag_wr) begin
            flags_d = ex_nzcv;
        end

        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    if (!c_bypass_en && br_type[1] && flag_wr) begin
                        // Flags for this branch are still in flight: hold one
                        // cycle and resolve from the registered copy.
                        state_d     = WAIT;
                        wait_type_d = br_type;
                        wait_tgt_d  = br_target;
                        stall_req_d = 1'b1;
                    end else if (taken_f(br_type, cbz_zero, eff_flags)) begin
                        state_d     = FLUSH;
                        cnt_d       = 2'd0;
                        br_pc_d     = br_target;
                        br_taken_d  = 1'b1;
                        flush_req_d = 1'b1;
                    end
                end
            end

            WAIT: begin
                // Only B.EQ/B.LT reach WAIT, so the CBZ operand is irrelevant
                if (taken_f(wait_type_q, 1'b0, flags_q)) begin
                    state_d     = FLUSH;
                    cnt_d       = 2'd0;
                    br_pc_d     = wait_tgt_q;
                    br_taken_d  = 1'b1;
                    flush_req_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            FLUSH: begin
                if (cnt_q == c_cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d       = cnt_q + 2'd1;
                    flush_req_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State registers: async reset, stall freezes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            flags_q     <= 4'd0;
            br_pc_q     <= '0;
            br_taken_q  <= 1'b0;
            flush_req_q <= 1'b0;
            stall_req_q <= 1'b0;
            wait_type_q <= 2'd0;
            wait_tgt_q  <= '0;
        end else if (!stall) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            br_pc_q     <= br_pc_d;
            br_taken_q  <= br_taken_d;
            flush_req_q <= flush_req_d;
            stall_req_q <= stall_req_d;
            wait_type_q <= wait_type_d;
            wait_tgt_q  <= wait_tgt_d;
        end
    end

    assign flags     = flags_q;
    assign br_taken  = br_taken_q;
    assign br_pc     = br_pc_q;
    assign flush_req = flush_req_q;
    assign stall_req = stall_req_q;

endmodule

`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
// ============================================================================
//  Module      : tb_flag_branch_unit
//  Description : Directed self-checking bench for flag_branch_unit
//                (ADDR_W=64, FLUSH_LEN=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        ex_valid;
    logic        ex_set_flags;
    logic [3:0]  ex_nzcv;
    logic        br_valid;
    logic [1:0]  br_type;
    logic        cbz_zero;
    logic [63:0] br_target;
    logic [3:0]  flags;
    logic        br_taken;
    logic [63:0] br_pc;
    logic        flush_req;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;

    flag_branch_unit #(.ADDR_W(64), .FLUSH_LEN(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_set_flags (ex_set_flags),
        .ex_nzcv      (ex_nzcv),
        .br_valid     (br_valid),
        .br_type      (br_type),
        .cbz_zero     (cbz_zero),
        .br_target    (br_target),
        .flags        (flags),
        .br_taken     (br_taken),
        .br_pc        (br_pc),
        .flush_req    (flush_req),
        .stall_req    (stall_req)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic tk, input logic fl, input logic sr);
        chk({tag, "_taken"}, 64'(br_taken), 64'(tk));
        chk({tag, "_flush"}, 64'(flush_req), 64'(fl));
        chk({tag, "_stallreq"}, 64'(stall_req), 64'(sr));
    endtask

    task automatic clear_in();
        ex_valid = 1'b0; ex_set_flags = 1'b0; ex_nzcv = 4'h0;
        br_valid = 1'b0; br_type = 2'b00; cbz_zero = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_target = 64'h0;
        clear_in();
        tick(); tick();
        // Reset state
        chk("rst_flags", 64'(flags), 64'h0);
        chk("rst_pc", br_pc, 64'h0);
        chk_out("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // Flag write, then non-flag-setting op leaves flags alone
        ex_valid = 1'b1; ex_set_flags = 1'b1; ex_nzcv = 4'b0100;
        tick();
        chk("flag_wr", 64'(flags), 64'h4);
        ex_set_flags = 1'b0; ex_nzcv = 4'b1111;
        tick();
        chk("flag_hold", 64'(flags), 64'h4);

        // Stall freezes flag register
        stall = 1'b1; ex_set_flags = 1'b1; ex_nzcv = 4'b1111;
        tick();
        chk("stall_flags", 64'(flags), 64'h4);
        stall = 1'b0;
        clear_in();

        // CBZ taken: one-cycle latency, two flush cycles
        br_valid = 1'b1; br_type = 2'b01; cbz_zero = 1'b1; br_target = 64'h40;
        tick();
        clear_in();
        chk("cbz_pc", br_pc, 64'h40);
        chk_out("cbz_c1", 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("cbz_c2", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("cbz_c3", 1'b0, 1'b0, 1'b0);

        // CBZ not taken: no redirect, br_pc keeps last value
        br_valid = 1'b1; br_type = 2'b01; cbz_zero = 1'b0; br_target = 64'h80;
        tick();
        clear_in();
        chk_out("cbz_nt", 1'b0, 1'b0, 1'b0);
        chk("cbz_nt_pc", br_pc, 64'h40);

        // B.EQ from registered flags (Z=1), then wrong-path activity in FLUSH
        br_valid = 1'b1; br_type = 2'b10; br_target = 64'h100;
        tick();
        chk_out("beq_c1", 1'b1, 1'b1, 1'b0);
        chk("beq_pc", br_pc, 64'h100);
        br_valid = 1'b1; br_type = 2'b00; br_target = 64'h200;
        ex_valid = 1'b1; ex_set_flags = 1'b1; ex_nzcv = 4'b0001;
        tick();
        clear_in();
        chk_out("wp_c2", 1'b0, 1'b1, 1'b0);
        chk("wp_flags", 64'(flags), 64'h4);
        chk("wp_pc", br_pc, 64'h100);
        tick();
        chk_out("wp_c3", 1'b0, 1'b0, 1'b0);

        // Clear flags, then B.LT with same-cycle N=1 flag update
        ex_valid = 1'b1; ex_set_flags = 1'b1; ex_nzcv = 4'b0000;
        tick();
        chk("flags_zero", 64'(flags), 64'h0);
        br_valid = 1'b1; br_type = 2'b11; br_target = 64'h300;
        ex_nzcv = 4'b1000;
        tick();
        clear_in();
        chk("blt_flags", 64'(flags), 64'h8);
`ifdef FLAG_BYPASS_EN
        chk_out("blt_c1", 1'b1, 1'b1, 1'b0);
        chk("blt_pc", br_pc, 64'h300);
        tick();
        chk_out("blt_c2", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("blt_c3", 1'b0, 1'b0, 1'b0);
`else
        chk_out("blt_wait", 1'b0, 1'b0, 1'b1);
        chk("blt_wait_pc", br_pc, 64'h100);
        tick();
        chk_out("blt_c1", 1'b1, 1'b1, 1'b0);
        chk("blt_pc", br_pc, 64'h300);
        tick();
        chk_out("blt_c2", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("blt_c3", 1'b0, 1'b0, 1'b0);
`endif

        // Stall held 3 cycles in the first FLUSH cycle
        br_valid = 1'b1; br_type = 2'b00; br_target = 64'h500;
        tick();
        clear_in();
        chk_out("stl_c1", 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stl_hold", 1'b1, 1'b1, 1'b0);
            chk("stl_pc", br_pc, 64'h500);
        end
        stall = 1'b0;
        tick();
        chk_out("stl_c2", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("stl_c3", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-FLUSH (counter=1)
        br_valid = 1'b1; br_type = 2'b00; br_target = 64'h600;
        tick();
        clear_in();
        tick();
        chk_out("ar_pre", 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_out("ar_async", 1'b0, 1'b0, 1'b0);
        chk("ar_pc", br_pc, 64'h0);
        chk("ar_flags", 64'(flags), 64'h0);
        tick();
        reset = 1'b0;
        tick();
        chk_out("ar_after", 1'b0, 1'b0, 1'b0);
        chk("ar_after_flags", 64'(flags), 64'h0);

        // Unit works normally after reset
        br_valid = 1'b1; br_type = 2'b00; br_target = 64'h700;
        tick();
        clear_in();
        chk_out("post_c1", 1'b1, 1'b1, 1'b0);
        chk("post_pc", br_pc, 64'h700);
        tick(); tick();
        chk_out("post_c3", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
